// File: rtl/fb_write_ctrl_if.sv
// Pixel-stream, RAM write-port and frame-control signals of the framebuffer write controller.
// master = the write controller itself; slave = the environment (pixel source, RAM, main FSM).
interface fb_write_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
);
    logic              START;
    logic              SCALE;
    logic [PIX_W-1:0]  PIX_IN;
    logic              PIX_VALID;
    logic              PIX_READY;
    logic              WREN;
    logic [ADDR_W-1:0] WADDR;
    logic [PIX_W-1:0]  WDATA;
    logic              BUSY;
    logic              DONE;

    modport master (
        input  START, SCALE, PIX_IN, PIX_VALID,
        output PIX_READY, WREN, WADDR, WDATA, BUSY, DONE
    );

    modport slave (
        output START, SCALE, PIX_IN, PIX_VALID,
        input  PIX_READY, WREN, WADDR, WDATA, BUSY, DONE
    );
endinterface

// File: rtl/fb_write_ctrl.sv
// Framebuffer write controller: accepts a raster pixel stream and writes it top-left into a
// DST_W-pitch buffer at 1x or 2x (2x2 nearest-neighbour replication), then pulses DONE.
module fb_write_ctrl #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int DST_W  = 320,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    fb_write_ctrl_if.master bus
);

    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(SRC_H - 1);
    localparam logic [ADDR_W-1:0] PITCH_1X = ADDR_W'(DST_W);
    localparam logic [ADDR_W-1:0] PITCH_2X = ADDR_W'(2 * DST_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_REPL,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic              scale_q, scale_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic [1:0]        repl_q, repl_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [PIX_W-1:0]  wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              start_ok;
    logic              at_last;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] wr0_addr;

    // done_q blocks a START arriving in the same cycle as the DONE pulse.
    assign xfer     = ready_q && bus.PIX_VALID;
    assign start_ok = (state_q == S_IDLE) && bus.START && !done_q;
    assign at_last  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign x_ext    = ADDR_W'(x_q);
    assign wr0_addr = row_base_q + (scale_q ? (x_ext << 1) : x_ext);

    always_comb begin
        // NOTE: every _d signal gets a default before the case so no path leaves one
        // unassigned; an unassigned path in always_comb would infer a latch.
        state_d    = state_q;
        scale_d    = scale_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        pix_addr_d = pix_addr_q;
        pix_data_d = pix_data_q;
        repl_d     = repl_q;
        last_d     = last_q;
        wren_d     = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d    = S_ACCEPT;
                    scale_d    = bus.SCALE;
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                end
            end

            S_ACCEPT: begin
                if (xfer) begin
                    wren_d     = 1'b1;
                    waddr_d    = wr0_addr;
                    wdata_d    = bus.PIX_IN;
                    pix_addr_d = wr0_addr;
                    pix_data_d = bus.PIX_IN;
                    last_d     = at_last;
                    repl_d     = 2'd1;
                    // Row base steps by one (1x) or two (2x) destination lines on wrap.
                    if (x_q == X_LAST) begin
                        x_d        = '0;
                        y_d        = y_q + 1'b1;
                        row_base_d = row_base_q + (scale_q ? PITCH_2X : PITCH_1X);
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (scale_q) begin
                        state_d = S_REPL;
                    end else if (at_last) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_REPL: begin
                wren_d  = 1'b1;
                wdata_d = pix_data_q;
                case (repl_q)
                    2'd1:    waddr_d = pix_addr_q + ADDR_ONE;
                    2'd2:    waddr_d = pix_addr_q + PITCH_1X;
                    default: waddr_d = pix_addr_q + PITCH_1X + ADDR_ONE;
                endcase
                repl_d = repl_q + 2'd1;
                if (repl_q == 2'd3) begin
                    state_d = last_q ? S_FIN : S_ACCEPT;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_ACCEPT);
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            scale_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
            repl_q     <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b0;
            wren_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scale_q    <= scale_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
            repl_q     <= repl_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
            wren_q     <= wren_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.PIX_READY = ready_q;
    assign bus.WREN      = wren_q;
    assign bus.WADDR     = waddr_q;
    assign bus.WDATA     = wdata_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;

endmodule
